sprite_rom_reader: RTL and testbench

- Parametrised sprite/bitmap ROM reader for the VGA pixel path; a successor to the fixed per-asset ROMs (background, countdown digits, KO banner).
- Converts the current draw coordinate plus a sprite origin into a ROM address, then returns the palette index with in-sprite and opaque flags after a fixed 2-cycle latency.
- Supports multi-frame animation strips, horizontal mirroring and a frame-synchronous auto-animation sequencer.

---
 rtl/sprite_rom_reader.sv | 169 ++++++++++++++++
 tb/tb_sprite_rom_reader.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_rom_reader.sv
// sprite_rom_reader: turns a draw coordinate plus sprite origin into a ROM
// address and returns the palette index two cycles later. Frame number and
// horizontal flip are latched only at vsync so a sprite never tears mid-scan.
// A small sequencer can step the animation frame every ANIM_DIV vsyncs.
module sprite_rom_reader #(
  parameter int    DATA_W      = 3,
  parameter int    SPRITE_W    = 64,
  parameter int    SPRITE_H    = 64,
  parameter int    NUM_FRAMES  = 4,
  parameter int    COORD_W     = 10,
  parameter int    TRANSPARENT = 0,
  parameter int    ANIM_DIV    = 8,
  parameter string INIT_FILE   = "./sprite/sprite.mif",
  localparam int   FRAME_W     = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               frame_start,
  input  logic               req_valid,
  input  logic [COORD_W-1:0] draw_x,
  input  logic [COORD_W-1:0] draw_y,
  input  logic [COORD_W-1:0] sprite_x,
  input  logic [COORD_W-1:0] sprite_y,
  input  logic [FRAME_W-1:0] frame_sel,
  input  logic               flip_h,
  input  logic               anim_en,
  input  logic               anim_loop,
  output logic               pix_valid,
  output logic               pix_in_sprite,
  output logic               pix_opaque,
  output logic [DATA_W-1:0]  pix_data,
  output logic [FRAME_W-1:0] cur_frame,
  output logic               anim_done
);

  localparam int FRAME_WORDS = SPRITE_W * SPRITE_H;
  localparam int DEPTH       = FRAME_WORDS * NUM_FRAMES;
  localparam int ADDR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int COL_W       = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int ROW_W       = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
  localparam int DIV_W       = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(NUM_FRAMES - 1);
  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(ANIM_DIV - 1);
  localparam logic [COORD_W:0]   SPR_W_C    = (COORD_W + 1)'(SPRITE_W);
  localparam logic [COORD_W:0]   SPR_H_C    = (COORD_W + 1)'(SPRITE_H);
  localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(SPRITE_W - 1);
  localparam logic [DATA_W-1:0]  TRANSP_C   = DATA_W'(TRANSPARENT);

  // Sprite image store, frames packed back to back (frame 0 first).
  logic [DATA_W-1:0] rom_mem [DEPTH];

  // Frame control state
  logic               flip_q, flip_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               anim_en_q, anim_en_d;
  logic               done_q, done_d;

  // Pipeline state
  logic               valid1_q, in1_q;
  logic [ADDR_W-1:0]  addr1_q;
  logic               pix_valid_q, pix_in_q, pix_opaque_q;
  logic [DATA_W-1:0]  pix_data_q;

  // Next frame/flip/divider, evaluated only at vsync; anim_en_q remembers the
  // previous mode so that entering animation restarts the strip at frame 0.
  always_comb begin
    flip_d    = flip_q;
    frame_d   = frame_q;
    div_d     = div_q;
    anim_en_d = anim_en_q;
    done_d    = 1'b0;
    if (frame_start) begin
      flip_d    = flip_h;
      anim_en_d = anim_en;
      if (!anim_en) begin
        frame_d = (frame_sel > LAST_FRAME) ? LAST_FRAME : frame_sel;
        div_d   = '0;
      end else if (!anim_en_q) begin
        frame_d = '0;
        div_d   = '0;
      end else if (div_q == DIV_LAST) begin
        div_d = '0;
        if (frame_q < LAST_FRAME) begin
          frame_d = frame_q + FRAME_W'(1);
          done_d  = !anim_loop && (frame_d == LAST_FRAME);
        end else if (anim_loop) begin
          frame_d = '0;
        end
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  // Frame control registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      flip_q    <= 1'b0;
      frame_q   <= '0;
      div_q     <= '0;
      anim_en_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      flip_q    <= flip_d;
      frame_q   <= frame_d;
      div_q     <= div_d;
      anim_en_q <= anim_en_d;
      done_q    <= done_d;
    end
  end

  // Stage 1 address math. Offsets carry one extra bit so a draw coordinate left
  // of / above the origin cannot alias into the box.
  logic [COORD_W:0]  dx, dy;
  logic              in_box;
  logic [COL_W-1:0]  col;
  logic [ADDR_W-1:0] addr_d;

  assign dx     = {1'b0, draw_x} - {1'b0, sprite_x};
  assign dy     = {1'b0, draw_y} - {1'b0, sprite_y};
  assign in_box = (draw_x >= sprite_x) && (dx < SPR_W_C) &&
                  (draw_y >= sprite_y) && (dy < SPR_H_C);
  assign col    = flip_q ? (COL_LAST - dx[COL_W-1:0]) : dx[COL_W-1:0];
  assign addr_d = in_box ? (ADDR_W'(frame_q) * ADDR_W'(FRAME_WORDS) +
                            ADDR_W'(dy[ROW_W-1:0]) * ADDR_W'(SPRITE_W) +
                            ADDR_W'(col))
                         : '0;

  // Stage 1 registers: address with its valid and in-box tags
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid1_q <= 1'b0;
      in1_q    <= 1'b0;
      addr1_q  <= '0;
    end else begin
      valid1_q <= req_valid;
      in1_q    <= in_box;
      addr1_q  <= addr_d;
    end
  end

  logic [DATA_W-1:0] rd_word;
  assign rd_word = rom_mem[addr1_q];

  // Stage 2: ROM read merged with the in-box gating into one register stage
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pix_valid_q  <= 1'b0;
      pix_in_q     <= 1'b0;
      pix_opaque_q <= 1'b0;
      pix_data_q   <= '0;
    end else begin
      pix_valid_q  <= valid1_q;
      pix_in_q     <= in1_q;
      pix_opaque_q <= in1_q && (rd_word != TRANSP_C);
      pix_data_q   <= in1_q ? rd_word : '0;
    end
  end

  assign pix_valid     = pix_valid_q;
  assign pix_in_sprite = pix_in_q;
  assign pix_opaque    = pix_opaque_q;
  assign pix_data      = pix_data_q;
  assign cur_frame     = frame_q;
  assign anim_done     = done_q;

endmodule

// File: tb/tb_sprite_rom_reader.sv
// Directed bench for sprite_rom_reader (64x64 sprite, 4 frames, ANIM_DIV=2).
// A second instance with NUM_FRAMES=3 exercises frame-number clamping.
module tb_sprite_rom_reader;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset_n, frame_start, req_valid, flip_h, anim_en, anim_loop;
  logic [9:0] draw_x, draw_y, sprite_x, sprite_y;
  logic [1:0] frame_sel;

  logic       pix_valid, pix_in_sprite, pix_opaque, anim_done;
  logic [2:0] pix_data;
  logic [1:0] cur_frame;

  logic       d3_pix_valid, d3_pix_in_sprite, d3_pix_opaque, d3_anim_done;
  logic [2:0] d3_pix_data;
  logic [1:0] d3_cur_frame;

  int errors = 0;
  int checks = 0;

  sprite_rom_reader #(.ANIM_DIV(2), .INIT_FILE("")) dut (
    .clock(clock), .reset_n(reset_n), .frame_start(frame_start), .req_valid(req_valid),
    .draw_x(draw_x), .draw_y(draw_y), .sprite_x(sprite_x), .sprite_y(sprite_y),
    .frame_sel(frame_sel), .flip_h(flip_h), .anim_en(anim_en), .anim_loop(anim_loop),
    .pix_valid(pix_valid), .pix_in_sprite(pix_in_sprite), .pix_opaque(pix_opaque),
    .pix_data(pix_data), .cur_frame(cur_frame), .anim_done(anim_done));

  sprite_rom_reader #(.NUM_FRAMES(3), .ANIM_DIV(2), .INIT_FILE("")) dut3 (
    .clock(clock), .reset_n(reset_n), .frame_start(frame_start), .req_valid(req_valid),
    .draw_x(draw_x), .draw_y(draw_y), .sprite_x(sprite_x), .sprite_y(sprite_y),
    .frame_sel(frame_sel), .flip_h(flip_h), .anim_en(anim_en), .anim_loop(anim_loop),
    .pix_valid(d3_pix_valid), .pix_in_sprite(d3_pix_in_sprite), .pix_opaque(d3_pix_opaque),
    .pix_data(d3_pix_data), .cur_frame(d3_cur_frame), .anim_done(d3_anim_done));

  // ROM image chosen by the bench: neighbouring rows/frames get different values.
  function automatic logic [2:0] pat(input int a);
    int v;
    v = a + 3 * (a >> 6) + 5 * (a >> 12) + 2;
    return 3'(v & 7);
  endfunction

  // Expected {valid, in_sprite, opaque, data} for an in-box pixel at ROM address a.
  function automatic logic [5:0] inbox(input int a);
    return {1'b1, 1'b1, (pat(a) != 3'd0), pat(a)};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_req(input logic [9:0] x, input logic [9:0] y);
    draw_x = x; draw_y = y; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    logic [5:0] got;
    reset_n = 1'b0; req_valid = 1'b1; draw_x = 10'd100; draw_y = 10'd50;
    repeat (3) step();
    checks++;
    if ({pix_valid, pix_in_sprite, pix_opaque, pix_data, cur_frame, anim_done} !== 9'd0) begin
      errors++; $display("FAIL reset_outputs: got %b expected 0", {pix_valid, pix_in_sprite, pix_opaque, pix_data, cur_frame, anim_done});
    end
    checks++;
    if ({d3_pix_valid, d3_pix_in_sprite, d3_pix_opaque, d3_pix_data, d3_cur_frame, d3_anim_done} !== 9'd0) begin
      errors++; $display("FAIL reset_outputs_dut3: got %b expected 0", {d3_pix_valid, d3_pix_in_sprite, d3_pix_opaque, d3_pix_data, d3_cur_frame, d3_anim_done});
    end
    reset_n = 1'b1;
    step();
    checks++;
    if (pix_valid !== 1'b0) begin
      errors++; $display("FAIL latency_one_cycle: pix_valid got %b expected 0", pix_valid);
    end
    req_valid = 1'b0;
    step();
    got = {pix_valid, pix_in_sprite, pix_opaque, pix_data};
    checks++;
    if (got !== inbox(0)) begin
      errors++; $display("FAIL first_pixel_origin: got %b expected %b", got, inbox(0));
    end
  endtask

  task automatic test_bounds();
    logic [5:0] got;
    do_req(10'd163, 10'd50); got = {pix_valid, pix_in_sprite, pix_opaque, pix_data};
    checks++;
    if (got !== inbox(63)) begin errors++; $display("FAIL bounds_x163: got %b expected %b", got, inbox(63)); end
    do_req(10'd164, 10'd50); got = {pix_valid, pix_in_sprite, pix_opaque, pix_data};
    checks++;
    if (got !== 6'b100000) begin errors++; $display("FAIL bounds_x164: got %b expected 100000", got); end
    do_req(10'd99, 10'd50); got = {pix_valid, pix_in_sprite, pix_opaque, pix_data};
    checks++;
    if (got !== 6'b100000) begin errors++; $display("FAIL bounds_x99: got %b expected 100000", got); end
    do_req(10'd100, 10'd113); got = {pix_valid, pix_in_sprite, pix_opaque, pix_data};
    checks++;
    if (got !== inbox(4032)) begin errors++; $display("FAIL bounds_y113: got %b expected %b", got, inbox(4032)); end
    do_req(10'd100, 10'd114); got = {pix_valid, pix_in_sprite, pix_opaque, pix_data};
    checks++;
    if (got !== 6'b100000) begin errors++; $display("FAIL bounds_y114: got %b expected 100000", got); end
    do_req(10'd100, 10'd49); got = {pix_valid, pix_in_sprite, pix_opaque, pix_data};
    checks++;
    if (got !== 6'b100000) begin errors++; $display("FAIL bounds_y49: got %b expected 100000", got); end
  endtask

  task automatic test_flip();
    logic [5:0] got;
    flip_h = 1'b1; anim_en = 1'b0; frame_sel = 2'd0;
    pulse_frame();
    do_req(10'd100, 10'd51); got = {pix_valid, pix_in_sprite, pix_opaque, pix_data};
    checks++;
    if (got !== inbox(127)) begin errors++; $display("FAIL flip_addr127: got %b expected %b", got, inbox(127)); end
    flip_h = 1'b0;
    do_req(10'd100, 10'd51); got = {pix_valid, pix_in_sprite, pix_opaque, pix_data};
    checks++;
    if (got !== inbox(127)) begin errors++; $display("FAIL flip_no_tear: got %b expected %b", got, inbox(127)); end
    do_req(10'd163, 10'd51); got = {pix_valid, pix_in_sprite, pix_opaque, pix_data};
    checks++;
    if (got !== inbox(64)) begin errors++; $display("FAIL flip_right_edge: got %b expected %b", got, inbox(64)); end
    // frame_start together with a request: that request still sees the old flip
    frame_start = 1'b1; draw_x = 10'd100; draw_y = 10'd51; req_valid = 1'b1;
    step();
    frame_start = 1'b0; req_valid = 1'b0;
    step();
    got = {pix_valid, pix_in_sprite, pix_opaque, pix_data};
    checks++;
    if (got !== inbox(127)) begin errors++; $display("FAIL flip_same_cycle_old: got %b expected %b", got, inbox(127)); end
    do_req(10'd100, 10'd51); got = {pix_valid, pix_in_sprite, pix_opaque, pix_data};
    checks++;
    if (got !== inbox(64)) begin errors++; $display("FAIL flip_same_cycle_new: got %b expected %b", got, inbox(64)); end
  endtask

  task automatic test_manual_frame();
    logic [5:0] got;
    anim_en = 1'b0; flip_h = 1'b0; frame_sel = 2'd2;
    pulse_frame();
    checks++;
    if (cur_frame !== 2'd2) begin errors++; $display("FAIL manual_frame2: got %0d expected 2", cur_frame); end
    do_req(10'd100, 10'd50); got = {pix_valid, pix_in_sprite, pix_opaque, pix_data};
    checks++;
    if (got !== inbox(8192)) begin errors++; $display("FAIL manual_addr8192: got %b expected %b", got, inbox(8192)); end
    frame_sel = 2'd3;
    pulse_frame();
    checks++;
    if (cur_frame !== 2'd3) begin errors++; $display("FAIL manual_frame3: got %0d expected 3", cur_frame); end
    checks++;
    if (d3_cur_frame !== 2'd2) begin errors++; $display("FAIL clamp_frame: got %0d expected 2", d3_cur_frame); end
    do_req(10'd100, 10'd50); got = {pix_valid, pix_in_sprite, pix_opaque, pix_data};
    checks++;
    if (got !== inbox(12288)) begin errors++; $display("FAIL manual_addr12288: got %b expected %b", got, inbox(12288)); end
    frame_sel = 2'd0;
    repeat (3) step();
    checks++;
    if (cur_frame !== 2'd3) begin errors++; $display("FAIL frame_held_without_vsync: got %0d expected 3", cur_frame); end
  endtask

  task automatic test_anim_loop();
    int exp_f[10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    int done_cnt = 0;
    logic [5:0] got;
    anim_en = 1'b1; anim_loop = 1'b1;
    for (int i = 0; i < 10; i++) begin
      pulse_frame();
      if (anim_done === 1'b1) done_cnt++;
      checks++;
      if (cur_frame !== 2'(exp_f[i])) begin
        errors++; $display("FAIL anim_loop_pulse%0d: got %0d expected %0d", i + 1, cur_frame, exp_f[i]);
      end
      step();
      if (anim_done === 1'b1) done_cnt++;
      if (i == 2) begin
        do_req(10'd100, 10'd50); got = {pix_valid, pix_in_sprite, pix_opaque, pix_data};
        checks++;
        if (got !== inbox(4096)) begin errors++; $display("FAIL anim_addr4096: got %b expected %b", got, inbox(4096)); end
      end
    end
    checks++;
    if (done_cnt !== 0) begin errors++; $display("FAIL anim_loop_no_done: got %0d expected 0", done_cnt); end
  endtask

  task automatic test_anim_once();
    int exp_f[12] = '{0, 0, 1, 1, 2, 2, 3, 3, 3, 3, 3, 3};
    int done_cnt = 0;
    anim_en = 1'b0; frame_sel = 2'd0;
    pulse_frame();
    anim_en = 1'b1; anim_loop = 1'b0;
    for (int i = 0; i < 12; i++) begin
      pulse_frame();
      if (anim_done === 1'b1) done_cnt++;
      checks++;
      if ({cur_frame, anim_done} !== {2'(exp_f[i]), (i == 6)}) begin
        errors++; $display("FAIL anim_once_pulse%0d: frame/done got %0d/%b expected %0d/%b", i + 1, cur_frame, anim_done, exp_f[i], (i == 6));
      end
      step();
      if (anim_done === 1'b1) done_cnt++;
    end
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL anim_done_count: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_transparent();
    logic [5:0] got;
    anim_en = 1'b0; frame_sel = 2'd0; flip_h = 1'b0;
    pulse_frame();
    do_req(10'd106, 10'd50); got = {pix_valid, pix_in_sprite, pix_opaque, pix_data};
    checks++;
    if (got !== 6'b110000) begin errors++; $display("FAIL transparent_word: got %b expected 110000", got); end
    do_req(10'd107, 10'd50); got = {pix_valid, pix_in_sprite, pix_opaque, pix_data};
    checks++;
    if (got !== 6'b111001) begin errors++; $display("FAIL opaque_neighbour: got %b expected 111001", got); end
  endtask

  task automatic test_back_to_back();
    logic [5:0] got;
    logic [5:0] exp;
    int vcnt = 0;
    frame_sel = 2'd1; flip_h = 1'b1;
    pulse_frame();
    for (int i = 0; i <= 64; i++) begin
      if (i < 64) begin
        draw_x = 10'(100 + i); draw_y = 10'd52; req_valid = 1'b1;
      end else begin
        req_valid = 1'b0;
      end
      step();
      got = {pix_valid, pix_in_sprite, pix_opaque, pix_data};
      if (pix_valid === 1'b1) vcnt++;
      if (i == 0) begin
        checks++;
        if (pix_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle_before: pix_valid got %b expected 0", pix_valid); end
      end else begin
        exp = inbox(4096 + 128 + 63 - (i - 1));
        checks++;
        if (got !== exp) begin errors++; $display("FAIL b2b_pixel%0d: got %b expected %b", i - 1, got, exp); end
      end
    end
    step();
    checks++;
    if (pix_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle_after: pix_valid got %b expected 0", pix_valid); end
    checks++;
    if (vcnt !== 64) begin errors++; $display("FAIL b2b_valid_count: got %0d expected 64", vcnt); end
  endtask

  task automatic test_reset_midstream();
    logic [5:0] got;
    draw_x = 10'd100; draw_y = 10'd50; req_valid = 1'b1;
    step();
    step();
    checks++;
    if (pix_valid !== 1'b1) begin errors++; $display("FAIL midstream_valid_before: got %b expected 1", pix_valid); end
    reset_n = 1'b0; req_valid = 1'b0;
    #1;
    checks++;
    if ({pix_valid, pix_in_sprite, pix_opaque, pix_data, cur_frame, anim_done} !== 9'd0) begin
      errors++; $display("FAIL midstream_async_clear: got %b expected 0", {pix_valid, pix_in_sprite, pix_opaque, pix_data, cur_frame, anim_done});
    end
    step();
    reset_n = 1'b1;
    step();
    draw_x = 10'd100; draw_y = 10'd50; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    checks++;
    if (pix_valid !== 1'b0) begin errors++; $display("FAIL midstream_early: pix_valid got %b expected 0", pix_valid); end
    step();
    got = {pix_valid, pix_in_sprite, pix_opaque, pix_data};
    checks++;
    if (got !== inbox(0)) begin errors++; $display("FAIL midstream_first_pixel: got %b expected %b", got, inbox(0)); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; frame_start = 1'b0; req_valid = 1'b0;
    flip_h = 1'b0; anim_en = 1'b0; anim_loop = 1'b0; frame_sel = 2'd0;
    draw_x = 10'd0; draw_y = 10'd0; sprite_x = 10'd100; sprite_y = 10'd50;
    for (int a = 0; a < 16384; a++) dut.rom_mem[a] = pat(a);
    for (int a = 0; a < 12288; a++) dut3.rom_mem[a] = 3'd0;
    test_reset();
    test_bounds();
    test_flip();
    test_manual_frame();
    test_anim_loop();
    test_anim_once();
    test_transparent();
    test_back_to_back();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
